note_lane_renderer: RTL
=======================

// Module: note_lane_renderer
// PURPOSE
//  Parametrised renderer for one scrolling drum-note lane on the 160x120 VGA framebuffer.
//  On a start pulse it latches per-slot note sequences and a lane origin.
//  It then emits one framebuffer write per cycle (x, y, colour, plot) to paint every slot's square.
//  Sits between the note-sequence/scroll logic and the vga_adapter plot port.
//  Generalises slot count, square size, slot pitch and channel count, and adds erase, skip, hold and done.
// PARAMETERS
//  NUM_SLOTS   10  number of note slots per lane
//  SQ_SIZE     4   square edge in pixels (>=1; power of two not required)
//  SLOT_PITCH  8   x distance between consecutive slot origins
//  X_W         8   x coordinate width
//  Y_W         7   y coordinate width
//  SKIP_EMPTY  0   1: slots with no note are skipped (not plotted); 0: painted with bg_colour
// PORTS
//  clk         in   1          system clock (CLOCK_50)
//  reset       in   1          synchronous, active-high reset
//  start       in   1          single-cycle request to render a frame of the lane
//  red_seq     in   NUM_SLOTS  bit i = red (don) note in slot i
//  yellow_seq  in   NUM_SLOTS  bit i = yellow (ka) note in slot i
//  origin_x    in   X_W        x of slot 0 top-left pixel
//  origin_y    in   Y_W        y of slot 0 top-left pixel
//  bg_colour   in   3          erase colour for empty slots
//  hold        in   1          stall: freeze traversal while high
//  x           out  X_W        pixel x
//  y           out  Y_W        pixel y
//  colour      out  3          pixel colour, RGB 1 bit each
//  plot        out  1          write strobe for x/y/colour
//  busy        out  1          high from accepted start until done
//  done        out  1          one-cycle pulse after the last pixel
// BEHAVIOUR
//  - Reset: state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; all latches and counters cleared.
//  - FSM states:
//    - IDLE: start=1 latches red_seq, yellow_seq, origin_x, origin_y and bg_colour; slot=0, xo=0, yo=0; goes to DRAW.
//    - DRAW: one pixel per non-held cycle; exit to FINISH after the last pixel.
//    - FINISH: done=1 for one cycle; returns to IDLE.
//  - busy=1 in DRAW and FINISH. start is ignored while busy; latched inputs are immune to mid-frame input changes.
//  - Traversal order: xo fastest (0..SQ_SIZE-1), then yo (0..SQ_SIZE-1), then slot (0..NUM_SLOTS-1).
//  - Outputs are registered. The first plot appears the cycle after start is accepted.
//    A full frame is NUM_SLOTS*SQ_SIZE^2 plot cycles. done follows the cycle after the last plot.
//  - Coordinates: x = origin_x + slot*SLOT_PITCH + xo, y = origin_y + yo.
//    Both are computed at full width and truncated mod 2^X_W / 2^Y_W (wrap, no clipping).
//  - Colour per slot:
//    - red only = 3'b100
//    - yellow only = 3'b110
//    - both = 3'b111 (big note)
//    - neither = bg_colour
//  - SKIP_EMPTY=1: an empty slot's pixels are not visited. The counter jumps to the next slot in one cycle,
//    and the empty slot generates 0 plot cycles. An all-empty frame goes DRAW -> FINISH within 1 cycle, with 0 plots.
//  - hold=1 in DRAW: plot=0, counters and outputs x/y/colour frozen; resumes the same pixel when hold drops.
//    hold is ignored in IDLE and FINISH.
//  - start coinciding with reset: reset wins. reset mid-frame: immediate IDLE, plot=0 the next cycle, no done pulse.
//  - start in the FINISH cycle is ignored; start the cycle after done is accepted (back-to-back frames).
// STRUCTURE
//  - Shared package (tatsujin_pkg): colour constants COL_RED=3'b100, COL_YELLOW=3'b110, COL_BIG=3'b111, COL_BLACK=3'b000;
//    FSM state encoding; 160x120 screen-size constants.
//  - One natural sub-module: square_scanner (SQ_SIZE parameter), which owns the xo/yo counters.
//    It has advance/hold inputs and a last_pixel output; the top holds the slot counter, latches, colour mux and FSM.
// TESTING
//  - Defaults, start with red=10'b0110101010, yellow=0, origin (10,20), bg=0 -> exactly 160 plots.
//    First pixel (10,20) with slot 0 colour 000; slot 1 pixel (18,20) colour 100; done 1 cycle after the last plot.
//  - red=10'b1, yellow=10'b11 -> slot 0 colour 111, slot 1 colour 110, slots 2..9 bg_colour.
//  - SKIP_EMPTY=1, red=10'b1000000001 -> exactly 32 plots, only at slot 0 and slot 9 coordinates (slot 9 x=origin_x+72..75).
//    An all-zero sequence -> 0 plots, done within 2 cycles of start.
//  - hold pulsed high for 5 cycles mid-slot 3 -> plot=0 during the hold; the pixel sequence resumes with none skipped or duplicated (total 160).
//  - origin_x=250 -> x wraps (250+4 -> 254, 258 -> 2); start re-asserted while busy -> ignored, the frame is unchanged.
//  - reset asserted at pixel 50 -> plot=0 and busy=0 next cycle, no done.
//    New start after reset -> a full 160-pixel frame from slot 0.

Source files
------------

// File: rtl/tatsujin_pkg.sv
// Shared constants and types for the drum-lane graphics blocks:
// colour codes, FSM state encoding, screen size and the slot colour helper.
package tatsujin_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_BIG    = 3'b111;
  localparam logic [2:0] COL_BLACK  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Colour of one slot: red (don), yellow (ka), both (big note), else background.
  function automatic logic [2:0] slot_colour(input logic red, input logic yellow,
                                             input logic [2:0] bg);
    logic [2:0] col;
    unique case ({red, yellow})
      2'b10:   col = COL_RED;
      2'b01:   col = COL_YELLOW;
      2'b11:   col = COL_BIG;
      default: col = bg;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/note_lane_renderer_if.sv
// Bundle between the scroll logic (master) and the lane renderer (slave).
// Handshake: start is a one-cycle request that is accepted only when busy=0;
// while busy=1 start is ignored. plot is a write strobe qualifying x/y/colour
// in the same cycle; the only back-pressure is hold, which pauses the pixel
// stream without losing or repeating a pixel. done pulses once per frame.
interface note_lane_renderer_if #(
  parameter int NUM_SLOTS = 10,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
);
  logic                 start;
  logic [NUM_SLOTS-1:0] red_seq;
  logic [NUM_SLOTS-1:0] yellow_seq;
  logic [X_W-1:0]       origin_x;
  logic [Y_W-1:0]       origin_y;
  logic [2:0]           bg_colour;
  logic                 hold;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [2:0]           colour;
  logic                 plot;
  logic                 busy;
  logic                 done;

  modport master (
    output start, red_seq, yellow_seq, origin_x, origin_y, bg_colour, hold,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, red_seq, yellow_seq, origin_x, origin_y, bg_colour, hold,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/note_lane_renderer_square_scanner.sv
// Walks the pixels of one SQ_SIZE x SQ_SIZE square, xo fastest then yo.
// Exposes the coordinates of the pixel after the current one so the caller
// can register them on the same edge the counters step.
module note_lane_renderer_square_scanner #(
  parameter int  SQ_SIZE = 4,
  localparam int SQ_W    = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  logic            hold,
  output logic [SQ_W-1:0] nxt_xo,
  output logic [SQ_W-1:0] nxt_yo,
  output logic            last_pixel
);

  logic [SQ_W-1:0] xo;
  logic [SQ_W-1:0] yo;
  logic            last_x;

  // Next-pixel arithmetic; wraps to (0,0) after the square's last pixel.
  always_comb begin
    last_x     = (xo == SQ_W'(SQ_SIZE - 1));
    last_pixel = last_x && (yo == SQ_W'(SQ_SIZE - 1));
    nxt_xo     = last_x ? '0 : xo + 1'b1;
    nxt_yo     = last_x ? (last_pixel ? '0 : yo + 1'b1) : yo;
  end

  // Counter register: cleared outside a frame, frozen while held.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      xo <= '0;
      yo <= '0;
    end else if (advance && !hold) begin
      xo <= nxt_xo;
      yo <= nxt_yo;
    end
  end

endmodule

// File: rtl/note_lane_renderer.sv
// Renders one drum-note lane: latches the note sequences and origin on start,
// then streams one registered framebuffer write per cycle for every slot square.
module note_lane_renderer
  import tatsujin_pkg::*;
#(
  parameter int NUM_SLOTS  = 10,
  parameter int SQ_SIZE    = 4,
  parameter int SLOT_PITCH = 8,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter bit SKIP_EMPTY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  note_lane_renderer_if.slave   lane,
  output state_t                state_dbg
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SQ_W   = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;

  state_t               state, state_nxt;
  logic [NUM_SLOTS-1:0] red_q, yel_q, occ_q, occ_in;
  logic [X_W-1:0]       ox_q, x_q, pix_ox, pix_x;
  logic [Y_W-1:0]       oy_q, y_q, pix_oy, pix_y;
  logic [2:0]           bg_q, colour_q, pix_bg;
  logic                 empty_q, plot_q;
  logic [SLOT_W-1:0]    slot_q, nxt_slot, first_slot, pix_slot;
  logic                 has_next, has_first;
  logic [SQ_W-1:0]      nxt_xo, nxt_yo, pix_xo, pix_yo;
  logic                 last_pixel, frame_end, advance, pix_red, pix_yel;

  assign occ_q  = red_q | yel_q;
  assign occ_in = lane.red_seq | lane.yellow_seq;

  // A frame ends with no pixels at all, or on an unheld step past the last pixel.
  assign frame_end = empty_q || (!lane.hold && last_pixel && !has_next);
  assign advance   = (state == ST_DRAW) && !empty_q && !frame_end;

  note_lane_renderer_square_scanner #(.SQ_SIZE(SQ_SIZE)) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != ST_DRAW),
    .advance    (advance),
    .hold       (lane.hold),
    .nxt_xo     (nxt_xo),
    .nxt_yo     (nxt_yo),
    .last_pixel (last_pixel)
  );

  // Slot search: lowest visited slot above the current one, and the first slot of a new frame.
  always_comb begin
    nxt_slot   = '0;
    has_next   = 1'b0;
    first_slot = '0;
    has_first  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i > int'(slot_q) && (!SKIP_EMPTY || occ_q[i])) begin
        nxt_slot = SLOT_W'(i);
        has_next = 1'b1;
      end
      if (!SKIP_EMPTY || occ_in[i]) begin
        first_slot = SLOT_W'(i);
        has_first  = 1'b1;
      end
    end
  end

  // Pixel to register next: the first pixel straight from the bus when idle, else the following one.
  always_comb begin
    pix_slot = first_slot;
    pix_xo   = '0;
    pix_yo   = '0;
    pix_ox   = lane.origin_x;
    pix_oy   = lane.origin_y;
    pix_bg   = lane.bg_colour;
    pix_red  = lane.red_seq[first_slot];
    pix_yel  = lane.yellow_seq[first_slot];
    if (state != ST_IDLE) begin
      pix_slot = last_pixel ? nxt_slot : slot_q;
      pix_xo   = nxt_xo;
      pix_yo   = nxt_yo;
      pix_ox   = ox_q;
      pix_oy   = oy_q;
      pix_bg   = bg_q;
      pix_red  = red_q[pix_slot];
      pix_yel  = yel_q[pix_slot];
    end
    // Coordinates wrap modulo the port widths; no clipping.
    pix_x = pix_ox + X_W'(int'(pix_slot) * SLOT_PITCH) + X_W'(pix_xo);
    pix_y = pix_oy + Y_W'(pix_yo);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (lane.start) state_nxt = ST_DRAW;
      ST_DRAW:   if (frame_end)  state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    lane.busy = (state != ST_IDLE);
    lane.done = (state == ST_FINISH);
    state_dbg = state;
  end

  // Datapath: input latches, slot counter and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_q    <= '0;
      yel_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      bg_q     <= '0;
      empty_q  <= 1'b0;
      slot_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          plot_q <= 1'b0;
          if (lane.start) begin
            red_q    <= lane.red_seq;
            yel_q    <= lane.yellow_seq;
            ox_q     <= lane.origin_x;
            oy_q     <= lane.origin_y;
            bg_q     <= lane.bg_colour;
            empty_q  <= !has_first;
            slot_q   <= first_slot;
            x_q      <= pix_x;
            y_q      <= pix_y;
            colour_q <= slot_colour(pix_red, pix_yel, pix_bg);
            plot_q   <= has_first;
          end
        end
        ST_DRAW: begin
          if (frame_end || lane.hold) begin
            plot_q <= 1'b0;
          end else begin
            if (last_pixel) slot_q <= nxt_slot;
            x_q      <= pix_x;
            y_q      <= pix_y;
            colour_q <= slot_colour(pix_red, pix_yel, pix_bg);
            plot_q   <= 1'b1;
          end
        end
        default: plot_q <= 1'b0;
      endcase
    end
  end

  assign lane.x      = x_q;
  assign lane.y      = y_q;
  assign lane.colour = colour_q;
  assign lane.plot   = plot_q;

endmodule
